// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing, reused by TX and RX.
// StParity is only reached when UART_TX_DRAIN_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned ClksPerBitDefault = 868;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StParity = 3'd4,
    StStop   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, pulses tickOut on the last count.
// clearIn restarts the count so every state starts a fresh bit period.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic clkIn,
  input  logic rstIn,
  input  logic clearIn,
  input  logic enableIn,
  output logic tickOut
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tickOut = enableIn && (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clearIn) begin
      cnt_d = '0;
    end else if (enableIn) begin
      cnt_d = tickOut ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream sync FIFO one character at a time (8N1 style).
// Define UART_TX_DRAIN_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  fifoEmptyIn,
  output logic                  fifoRdEnOut,
  input  logic [DATA_WIDTH-1:0] fifoDataIn,
  output logic                  txOut,
  output logic                  busyOut
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  baud_en, baud_clr, baud_tick;
`ifdef UART_TX_DRAIN_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Gated by reset so no pop can escape while the FSM is being forced to IDLE.
  assign fifoRdEnOut = (state_q == StIdle) && !fifoEmptyIn && !rstIn;
  assign busyOut     = (state_q != StIdle);
  assign txOut       = tx_q;
  assign baud_clr    = (state_d != state_q);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .clearIn (baud_clr),
    .enableIn(baud_en),
    .tickOut (baud_tick)
  );

  // tx_d follows the current state, so the line lags the FSM by one cycle uniformly.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = 1'b1;
    baud_en = 1'b0;
`ifdef UART_TX_DRAIN_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifoEmptyIn) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d = fifoDataIn;
        bit_d   = '0;
`ifdef UART_TX_DRAIN_PARITY_EN
        parity_d = ^fifoDataIn;
`endif
        state_d = StStart;
      end
      StStart: begin
        tx_d    = 1'b0;
        baud_en = 1'b1;
        if (baud_tick) begin
          state_d = StData;
        end
      end
      StData: begin
        tx_d    = shift_q[0];
        baud_en = 1'b1;
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef UART_TX_DRAIN_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_DRAIN_PARITY_EN
      StParity: begin
        tx_d    = parity_q;
        baud_en = 1'b1;
        if (baud_tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        tx_d    = 1'b1;
        baud_en = 1'b1;
        if (baud_tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= StIdle;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model with 1-cycle read latency, line monitor with a byte
// scoreboard, reset vector table and hand-written back-to-back / abort / noise sequences.
module tb_uart_tx_drain;

  localparam int Cpb = 4;
  localparam int Dw  = 8;
`ifdef UART_TX_DRAIN_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int FrameLen = NBits * Cpb;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [Dw-1:0] fifo_data = '0;
  logic          tx;
  logic          busy;

  uart_tx_drain #(
    .DATA_WIDTH  (Dw),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clkIn      (clk_in),
    .rstIn      (rst_in),
    .fifoEmptyIn(fifo_empty),
    .fifoRdEnOut(fifo_rd_en),
    .fifoDataIn (fifo_data),
    .txOut      (tx),
    .busyOut    (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO model
  logic [Dw-1:0] fifo_q[$];
  logic [Dw-1:0] exp_q[$];
  bit   force_en  = 1'b1;
  bit   force_val = 1'b0;
  int   pops       = 0;
  int   extra_pops = 0;

  task automatic upd_empty();
    fifo_empty = force_en ? force_val : (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [Dw-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    upd_empty();
  endtask

  always @(posedge clk_in) begin
    if (fifo_rd_en) begin
      pops++;
      if (fifo_q.size() == 0) begin
        extra_pops++;
      end else begin
        fifo_data <= fifo_q.pop_front();
      end
      fifo_empty <= force_en ? force_val : (fifo_q.size() == 0);
    end
  end

  function automatic logic [NBits-1:0] frame_bits(input logic [Dw-1:0] b);
    logic [NBits-1:0] f;
    f        = '1;
    f[0]     = 1'b0;
    f[Dw:1]  = b;
`ifdef UART_TX_DRAIN_PARITY_EN
    f[Dw+1]  = ^b;
`endif
    return f;
  endfunction

  // Line monitor
  int               cyc = 0;
  int               idx = 0;
  int               last_end = 0;
  int               gap = -1;
  int               frames = 0;
  bit               in_frame = 1'b0;
  bit               rogue = 1'b0;
  logic [NBits-1:0] cur_bits;

  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        idx      = 0;
        gap      = cyc - last_end - 1;
        frames++;
        if (exp_q.size() == 0) begin
          rogue = 1'b1;
          chk("unexpected_frame", 1, 0);
        end else begin
          rogue    = 1'b0;
          cur_bits = frame_bits(exp_q.pop_front());
          chk("busy_at_start", int'(busy), 1);
        end
      end
      if (in_frame) begin
        if (!rogue) begin
          chk($sformatf("tx_bit%0d_cyc%0d", idx / Cpb, idx % Cpb), int'(tx),
              int'(cur_bits[idx / Cpb]));
        end
        if (idx == FrameLen - 1) begin
          if (!rogue) chk("busy_at_frame_end", int'(busy), 0);
          in_frame = 1'b0;
          last_end = cyc;
        end
        idx++;
      end
    end
  end

  task automatic wait_done(input string name);
    int  budget;
    bit  done;
    budget = 2000;
    done   = 1'b0;
    while (!done && budget > 0) begin
      @(negedge clk_in);
      #1;
      budget--;
      done = (exp_q.size() == 0) && !in_frame && (fifo_q.size() == 0) && !busy;
    end
    chk({name, "_timeout"}, int'(done), 1);
    repeat (3) @(negedge clk_in);
    #1;
  endtask

  typedef struct {
    bit rst;
    bit empty;
    bit exp_rd;
    bit exp_tx;
    bit exp_busy;
  } vec_t;

  vec_t vecs[7];
  int   p0;
  int   f0;

  initial begin
    vecs[0] = '{1, 0, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 1, 0};
    vecs[2] = '{1, 0, 0, 1, 0};
    vecs[3] = '{1, 1, 0, 1, 0};
    vecs[4] = '{1, 0, 0, 1, 0};
    vecs[5] = '{0, 1, 0, 1, 0};
    vecs[6] = '{0, 1, 0, 1, 0};

    rst_in = 1'b1;
    upd_empty();
    repeat (2) @(negedge clk_in);

    // Reset held with a non-empty flag, then quiet idle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      #1;
      rst_in    = vecs[i].rst;
      force_val = vecs[i].empty;
      upd_empty();
      @(posedge clk_in);
      #1;
      chk($sformatf("vec%0d_rd_en", i), int'(fifo_rd_en), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_tx", i), int'(tx), int'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
    end
    chk("reset_no_pops", pops, 0);

    @(negedge clk_in);
    #1;
    force_en = 1'b0;
    upd_empty();

    // Single character 0xA5
    p0 = pops;
    f0 = frames;
    push(8'hA5);
    wait_done("a5");
    chk("a5_pops", pops - p0, 1);
    chk("a5_frames", frames - f0, 1);

    // Back-to-back 0x55, 0x0F
    p0 = pops;
    f0 = frames;
    push(8'h55);
    push(8'h0F);
    wait_done("b2b");
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_frames", frames - f0, 2);
    chk("b2b_gap", gap, 2);
    chk("b2b_fifo_empty", int'(fifo_empty), 1);

    // Parity-relevant bytes (odd and even popcount)
    p0 = pops;
    push(8'h07);
    push(8'h03);
    wait_done("par");
    chk("par_pops", pops - p0, 2);

    // Reset during DATA bit 3 of 0xFF; 0x3C must follow intact
    p0 = pops;
    f0 = frames;
    push(8'hFF);
    push(8'h3C);
    begin
      int budget = 500;
      while (!(in_frame && idx == 17) && budget > 0) begin
        @(negedge clk_in);
        #1;
        budget--;
      end
      chk("abort_reach_bit3", int'(in_frame && idx == 17), 1);
    end
    rst_in = 1'b1;
    #1;
    chk("abort_rd_en_in_reset", int'(fifo_rd_en), 0);
    @(negedge clk_in);
    #1;
    chk("abort_tx_high", int'(tx), 1);
    chk("abort_busy_low", int'(busy), 0);
    rst_in = 1'b0;
    wait_done("abort");
    chk("abort_pops", pops - p0, 2);
    chk("abort_frames", frames - f0, 2);

    // Noise on the empty flag mid-frame must not disturb the frame or pop
    p0 = pops;
    push(8'h96);
    begin
      int budget = 500;
      while (!(in_frame && idx >= 2) && budget > 0) begin
        @(negedge clk_in);
        #1;
        budget--;
      end
      chk("noise_reach_frame", int'(in_frame), 1);
    end
    force_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      force_val = 1'($urandom_range(0, 1));
      upd_empty();
      @(negedge clk_in);
      #1;
    end
    force_en = 1'b0;
    upd_empty();
    wait_done("noise");
    chk("noise_pops", pops - p0, 1);

    chk("no_extra_pops", extra_pops, 0);
    chk("idle_tx_high", int'(tx), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
